freelist_ckpt: RTL and testbench

FREELIST_CKPT -- requirements
Module: freelist_ckpt

---
 rtl/cpu_ooo_pkg.sv | 10 +
 rtl/ckpt_table.sv | 26 ++
 rtl/freelist_ckpt.sv | 65 ++++++
 tb/tb_freelist_ckpt.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ooo_pkg.sv
// rtl/cpu_ooo_pkg.sv - shared core sizing and tag type for rename, RAT and register file
package cpu_ooo_pkg;
   localparam int PHYS_REGS_DEF  = 64;
   localparam int ARCH_REGS_DEF  = 32;
   localparam int CKPT_DEPTH_DEF = 8;
   localparam int TAG_W_DEF      = $clog2(PHYS_REGS_DEF);
   localparam int PAGE_W_DEF     = $clog2(CKPT_DEPTH_DEF);

   typedef logic [TAG_W_DEF-1:0] tag_t;
endpackage

// File: rtl/ckpt_table.sv
// rtl/ckpt_table.sv - branch checkpoint page array, one write port, one async read port
module ckpt_table #(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = 6,
   localparam int AW    = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] pages [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) pages[i] <= '0;
      end else if (wr_en) begin
         pages[wr_addr] <= wr_data;
      end
   end

   assign rd_data = pages[rd_addr];
endmodule

// File: rtl/freelist_ckpt.sv
// rtl/freelist_ckpt.sv - physical register free list with branch checkpoints of the head pointer
module freelist_ckpt
   import cpu_ooo_pkg::*;
#(
   parameter int PHYS_REGS  = PHYS_REGS_DEF,
   parameter int ARCH_REGS  = ARCH_REGS_DEF,
   parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
   localparam int TAG_W     = $clog2(PHYS_REGS),
   localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS,
   localparam int PTR_W     = $clog2(FL_DEPTH),
   localparam int PAGE_W    = $clog2(CKPT_DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   output logic              alloc_valid,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              rel_valid,
   input  logic [TAG_W-1:0]  rel_tag,
   input  logic              save_on,
   input  logic [PAGE_W-1:0] save_page,
   input  logic              restore_on,
   input  logic [PAGE_W-1:0] restore_page,
   output logic [PTR_W:0]    free_count,
   output logic              overflow_err
);
   logic [TAG_W-1:0] buffer [FL_DEPTH];
   logic [PTR_W:0]   head, tail, head_next, ckpt_head;
   logic             full, pop, push;

   assign free_count  = tail - head;
   assign full        = (free_count == (PTR_W+1)'(FL_DEPTH));
   assign alloc_valid = (free_count != '0) && !restore_on;
   assign alloc_tag   = buffer[head[PTR_W-1:0]];
   assign pop         = alloc_req && alloc_valid;
   assign push        = rel_valid && !full;
   assign head_next   = head + (PTR_W+1)'(pop);

   // Checkpoints capture the post-pop head, so a same-cycle allocation is kept on restore.
   ckpt_table #(.DEPTH(CKPT_DEPTH), .WIDTH(PTR_W+1)) u_ckpt (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (save_on && !restore_on),
      .wr_addr (save_page),
      .wr_data (head_next),
      .rd_addr (restore_page),
      .rd_data (ckpt_head)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head         <= '0;
         tail         <= {1'b1, {PTR_W{1'b0}}};
         overflow_err <= 1'b0;
         for (int i = 0; i < FL_DEPTH; i++) buffer[i] <= TAG_W'(ARCH_REGS + i);
      end else begin
         head <= restore_on ? ckpt_head : head_next;
         if (push) begin
            buffer[tail[PTR_W-1:0]] <= rel_tag;
            tail                    <= tail + 1'b1;
         end
         if (rel_valid && full) overflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_freelist_ckpt.sv
// tb/tb_freelist_ckpt.sv - directed checks of free list pop/push, checkpoints and reset
module tb_freelist_ckpt;
   import cpu_ooo_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req, alloc_valid;
   tag_t       alloc_tag, rel_tag;
   logic       rel_valid, save_on, restore_on, overflow_err;
   logic [2:0] save_page, restore_page;
   logic [5:0] free_count;
   int         tests = 0;
   int         fails = 0;

   freelist_ckpt dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_valid  (alloc_valid),
      .alloc_tag    (alloc_tag),
      .rel_valid    (rel_valid),
      .rel_tag      (rel_tag),
      .save_on      (save_on),
      .save_page    (save_page),
      .restore_on   (restore_on),
      .restore_page (restore_page),
      .free_count   (free_count),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle();
      alloc_req    = 1'b0;
      rel_valid    = 1'b0;
      rel_tag      = '0;
      save_on      = 1'b0;
      save_page    = '0;
      restore_on   = 1'b0;
      restore_page = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic alloc_n(input int n);
      alloc_req = 1'b1;
      repeat (n) tick();
      alloc_req = 1'b0;
   endtask

   initial begin
      idle();
      do_reset();
      check("rst_valid", alloc_valid, 1);
      check("rst_tag", alloc_tag, 32);
      check("rst_count", free_count, 32);
      check("rst_ovf", overflow_err, 0);

      // release into a full list is dropped and latches the error
      rel_valid = 1'b1; rel_tag = 6'd9;
      tick();
      idle();
      check("ovf_set", overflow_err, 1);
      check("ovf_count", free_count, 32);
      check("ovf_tag", alloc_tag, 32);
      alloc_n(2);
      check("ovf_sticky", overflow_err, 1);
      do_reset();

      // drain the list in order
      for (int i = 0; i < 32; i++) begin
         check($sformatf("drain_tag%0d", i), alloc_tag, 32 + i);
         check($sformatf("drain_vld%0d", i), alloc_valid, 1);
         alloc_n(1);
      end
      check("empty_valid", alloc_valid, 0);
      check("empty_count", free_count, 0);
      alloc_n(1);
      check("empty_ignored", free_count, 0);

      // push into empty
      rel_valid = 1'b1; rel_tag = 6'd5;
      tick();
      idle();
      check("push_valid", alloc_valid, 1);
      check("push_tag", alloc_tag, 5);
      check("push_count", free_count, 1);

      // simultaneous pop and push
      alloc_req = 1'b1; rel_valid = 1'b1; rel_tag = 6'd11;
      tick();
      idle();
      check("popush_count", free_count, 1);
      check("popush_tag", alloc_tag, 11);

      // save alongside the third alloc, then restore
      do_reset();
      alloc_n(2);
      alloc_req = 1'b1; save_on = 1'b1; save_page = 3'd2;
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("post_save_tag%0d", i), alloc_tag, 35 + i);
         alloc_n(1);
      end
      restore_on = 1'b1; restore_page = 3'd2; alloc_req = 1'b1;
      #1;
      check("restore_cycle_valid", alloc_valid, 0);
      tick();
      idle();
      check("restore_tag", alloc_tag, 35);
      check("restore_count", free_count, 29);

      // save dropped when restore happens in the same cycle
      alloc_n(2);
      save_on = 1'b1; save_page = 3'd4; restore_on = 1'b1; restore_page = 3'd2;
      tick();
      idle();
      check("both_tag", alloc_tag, 35);
      restore_on = 1'b1; restore_page = 3'd4;
      tick();
      idle();
      check("dropped_save_tag", alloc_tag, 32);
      check("dropped_save_count", free_count, 32);

      // restore with concurrent release after draining
      do_reset();
      alloc_n(3);
      save_on = 1'b1; save_page = 3'd2;
      tick();
      idle();
      alloc_n(29);
      check("drained_count", free_count, 0);
      restore_on = 1'b1; restore_page = 3'd2; rel_valid = 1'b1; rel_tag = 6'd7;
      tick();
      idle();
      check("rr_count", free_count, 30);
      for (int i = 0; i < 29; i++) begin
         check($sformatf("rr_tag%0d", i), alloc_tag, 35 + i);
         alloc_n(1);
      end
      check("rr_tag7", alloc_tag, 7);
      check("rr_last_count", free_count, 1);

      // async reset mid-burst
      rel_valid = 1'b1; rel_tag = 6'd3;
      alloc_req = 1'b1;
      tick();
      tick();
      rel_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", alloc_valid, 1);
      check("mid_rst_tag", alloc_tag, 32);
      check("mid_rst_count", free_count, 32);
      check("mid_rst_ovf", overflow_err, 0);
      idle();
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_tag", alloc_tag, 32);
      check("post_rst_count", free_count, 32);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
